// File: rtl/vga_pkg.sv
// 640x480@60 timing shared with the VGA generator,
// plus lock-FSM encoding and saturating counter helpers.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] CNT_PRE = 11'h7FE;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  function automatic logic [10:0] sat_inc(
    input logic [10:0] v
  );
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat10(
    input logic [10:0] v
  );
    return v[10] ? 10'h3FF : v[9:0];
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Input register with rise/fall pulses taken
// from the registered value and its delayed copy.
module sync_edge_det #(
  parameter int W = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] q_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= INIT;
      q_d <= INIT;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA sink: recovers pixel coordinates and strobes,
// measures line/frame timing and tracks format lock.
module vga_rx_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blk,
  input  logic [23:0] vga_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [10:0] v_period,
  output logic        locked,
  output logic        fmt_err
);

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

  logic hs_q, hs_rise, hs_fall;
  logic vs_q, vs_rise, vs_fall;
  logic blk_q, blk_rise, blk_fall;
  logic [23:0] rgb_q;

  sync_edge_det #(.W(1), .INIT(1'b1)) u_hs (
    .clk(clk), .rst(rst), .d(vga_hs),
    .q(hs_q), .rise(hs_rise), .fall(hs_fall)
  );

  sync_edge_det #(.W(1), .INIT(1'b1)) u_vs (
    .clk(clk), .rst(rst), .d(vga_vs),
    .q(vs_q), .rise(vs_rise), .fall(vs_fall)
  );

  sync_edge_det #(.W(1), .INIT(1'b0)) u_blk (
    .clk(clk), .rst(rst), .d(vga_blk),
    .q(blk_q), .rise(blk_rise), .fall(blk_fall)
  );

  logic unused_sig;
  assign unused_sig = ^{hs_q, vs_q, hs_rise, vs_rise};

  logic [10:0] hcnt, lcnt, xcnt, ycnt;
  logic [10:0] x_cur;
  logic [3:0]  good_cnt, good_nx;
  logic        frame_bad;
  logic        h_bad, w_bad, v_bad, timeout;
  logic        err_nx;
  lock_state_t state, state_nx;

  assign x_cur = blk_rise ? 11'd0 : xcnt;

  assign h_bad = hs_fall && (sat_inc(hcnt) != HT);
  assign w_bad = blk_fall && (xcnt != HA);
  assign v_bad = vs_fall &&
    (frame_bad || lcnt != VT || ycnt != VA);

  // Fires once, on the step into saturation.
  assign timeout =
    (!hs_fall && hcnt == CNT_PRE) ||
    (hs_fall && !vs_fall && lcnt == CNT_PRE);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_nx   = 1'b0;
    unique case (state)
      ST_UNLOCKED: begin
        if (vs_fall) begin
          state_nx = ST_TRACK;
          good_nx  = '0;
        end
      end
      ST_TRACK: begin
        if (vs_fall) begin
          if (v_bad) begin
            good_nx = '0;
            err_nx  = 1'b1;
          end else if (good_cnt + 4'd1 >= LF) begin
            state_nx = ST_LOCKED;
            good_nx  = '0;
          end else begin
            good_nx = good_cnt + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (h_bad || w_bad || v_bad) begin
          state_nx = ST_UNLOCKED;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = ST_UNLOCKED;
    endcase
    if (timeout) begin
      state_nx = ST_UNLOCKED;
      good_nx  = '0;
      err_nx   = (state != ST_UNLOCKED);
    end
  end

  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q       <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_period    <= '0;
      v_period    <= '0;
      hcnt        <= '0;
      lcnt        <= '0;
      xcnt        <= '0;
      ycnt        <= '0;
      frame_bad   <= 1'b0;
      good_cnt    <= '0;
      state       <= ST_UNLOCKED;
      fmt_err     <= 1'b0;
    end else begin
      rgb_q       <= vga_rgb;
      pix_valid   <= blk_q;
      pix_data    <= blk_q ? rgb_q : '0;
      pix_x       <= blk_q ? sat10(x_cur) : '0;
      pix_y       <= blk_q ? sat10(ycnt) : '0;
      line_start  <= blk_rise;
      frame_start <= blk_rise && (ycnt == '0);

      hcnt <= hs_fall ? 11'd0 : sat_inc(hcnt);
      if (hs_fall)
        h_period <= sat_inc(hcnt);

      // A coincident HS fall opens the new frame.
      if (vs_fall) begin
        v_period <= lcnt;
        lcnt     <= {10'd0, hs_fall};
      end else if (hs_fall) begin
        lcnt <= sat_inc(lcnt);
      end

      if (blk_q)
        xcnt <= blk_rise ? 11'd1 : sat_inc(xcnt);

      if (vs_fall)
        ycnt <= '0;
      else if (blk_fall)
        ycnt <= sat_inc(ycnt);

      if (vs_fall)
        frame_bad <= 1'b0;
      else
        frame_bad <= frame_bad | h_bad | w_bad;

      state    <= state_nx;
      good_cnt <= good_nx;
      fmt_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a
// shrunken 40x20 raster with a 24x12 active area.
module tb_vga_rx_decoder;

  localparam int H_ACT  = 24;
  localparam int H_TOT  = 40;
  localparam int HS_BEG = 28;
  localparam int HS_END = 34;
  localparam int V_ACT  = 12;
  localparam int V_TOT  = 20;
  localparam int VS_BEG = 14;
  localparam int VS_END = 16;

  localparam int M_NONE    = 0;
  localparam int M_STRETCH = 1;
  localparam int M_HOLD    = 2;
  localparam int M_SHORT   = 3;

  typedef struct packed {
    logic        blk;
    logic        fs;
    logic        ls;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_hs, vga_vs, vga_blk;
  logic [23:0] vga_rgb;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        line_start, frame_start;
  logic [10:0] h_period, v_period;
  logic        locked, fmt_err;

  vga_rx_decoder #(
    .H_TOTAL(H_TOT), .V_TOTAL(V_TOT),
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blk(vga_blk), .vga_rgb(vga_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start),
    .frame_start(frame_start),
    .h_period(h_period), .v_period(v_period),
    .locked(locked), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  pix_t cur, p1, p2;
  bit   chk_pix = 1'b0;
  int   err_cnt = 0;
  int   fs_cnt  = 0;
  int   mon_err = 0;
  int   max_x   = 0;
  int   max_y   = 0;

  always @(posedge clk) begin
    p1 <= cur;
    p2 <= p1;
  end

  always @(negedge clk) begin
    if (fmt_err === 1'b1)
      err_cnt <= err_cnt + 1;
    if (frame_start === 1'b1)
      fs_cnt <= fs_cnt + 1;
    if (chk_pix) begin
      if (pix_valid !== p2.blk || pix_data !== p2.rgb ||
          pix_x !== p2.x || pix_y !== p2.y ||
          line_start !== p2.ls || frame_start !== p2.fs)
        mon_err <= mon_err + 1;
      if (pix_valid === 1'b1 && int'(pix_x) > max_x)
        max_x <= int'(pix_x);
      if (pix_valid === 1'b1 && int'(pix_y) > max_y)
        max_y <= int'(pix_y);
    end
  end

  task automatic drive_line(
    input int ln, input int h0, input int h1,
    input int blen, input bit hold
  );
    bit act;
    for (int h = h0; h < h1; h++) begin
      @(negedge clk);
      act     = (ln < V_ACT) && (h < blen);
      vga_hs  = hold || !(h >= HS_BEG && h < HS_END);
      vga_vs  = !(ln >= VS_BEG && ln < VS_END);
      vga_blk = act;
      vga_rgb = act ? 24'(ln * H_ACT + h) : 24'd0;
      cur.blk = act;
      cur.fs  = act && h == 0 && ln == 0;
      cur.ls  = act && h == 0;
      cur.x   = act ? 10'(h) : 10'd0;
      cur.y   = act ? 10'(ln) : 10'd0;
      cur.rgb = vga_rgb;
    end
  endtask

  task automatic drive_lines(
    input int l0, input int l1,
    input int mln, input int mode
  );
    for (int ln = l0; ln < l1; ln++) begin
      int len;
      int bl;
      bit hold;
      len  = H_TOT;
      bl   = H_ACT;
      hold = 1'b0;
      if (ln == mln && mode == M_STRETCH) len = H_TOT + 1;
      if (ln == mln && mode == M_HOLD) begin
        len  = 2100;
        hold = 1'b1;
      end
      if (ln == mln && mode == M_SHORT) bl = H_ACT - 1;
      drive_line(ln, 0, len, bl, hold);
    end
  endtask

  task automatic frame();
    drive_lines(0, V_TOT, -1, M_NONE);
  endtask

  int e0;

  initial begin
    rst = 1'b0;
    vga_hs = 1'b1; vga_vs = 1'b1;
    vga_blk = 1'b0; vga_rgb = '0;
    cur = '0;
    repeat (3) @(negedge clk);
    check("rst_pix", 64'({pix_valid, pix_data, pix_x,
          pix_y, line_start, frame_start}), 64'd0);
    check("rst_stat", 64'({h_period, v_period,
          locked, fmt_err}), 64'd0);
    rst = 1'b1;
    chk_pix = 1'b1;

    // Clean stream: lock after the second full frame
    frame();
    check("f0_locked", 64'(locked), 64'd0);
    check("f0_fs_cnt", 64'(fs_cnt), 64'd1);
    frame();
    check("f1_locked", 64'(locked), 64'd0);
    check("h_period", 64'(h_period), 64'd40);
    check("v_period", 64'(v_period), 64'd20);
    frame();
    check("f2_locked", 64'(locked), 64'd1);
    check("fs_per_frame", 64'(fs_cnt), 64'd3);
    check("no_err_clean", 64'(err_cnt), 64'd0);
    check("max_x", 64'(max_x), 64'd23);
    check("max_y", 64'(max_y), 64'd11);
    check("stream_f0_2", 64'(mon_err), 64'd0);

    // One 41-clk line while locked
    e0 = err_cnt;
    drive_lines(0, 6, 5, M_STRETCH);
    check("pre_stretch_err", 64'(err_cnt - e0), 64'd0);
    check("pre_stretch_lock", 64'(locked), 64'd1);
    drive_lines(6, 7, -1, M_NONE);
    check("stretch_err", 64'(err_cnt - e0), 64'd1);
    check("stretch_lock", 64'(locked), 64'd0);
    check("stretch_hper", 64'(h_period), 64'd41);
    drive_lines(7, V_TOT, -1, M_NONE);
    frame();
    check("relock_wait", 64'(locked), 64'd0);
    frame();
    check("relock", 64'(locked), 64'd1);
    check("stretch_once", 64'(err_cnt - e0), 64'd1);

    // HS held high for 2100 clk
    e0 = err_cnt;
    drive_lines(0, 18, 17, M_HOLD);
    check("timeout_err", 64'(err_cnt - e0), 64'd1);
    check("timeout_lock", 64'(locked), 64'd0);
    drive_lines(18, 19, -1, M_NONE);
    check("hper_sat", 64'(h_period), 64'd2047);
    drive_lines(19, V_TOT, -1, M_NONE);
    frame();
    check("timeout_once", 64'(err_cnt - e0), 64'd1);
    check("timeout_track", 64'(locked), 64'd0);

    // 23-clk BLK line inside a tracked frame
    e0 = err_cnt;
    drive_lines(0, V_TOT, 3, M_SHORT);
    check("short_err", 64'(err_cnt - e0), 64'd1);
    check("short_lock", 64'(locked), 64'd0);
    frame();
    check("short_delay", 64'(locked), 64'd0);
    frame();
    check("short_relock", 64'(locked), 64'd1);
    check("short_once", 64'(err_cnt - e0), 64'd1);
    check("stream_all", 64'(mon_err), 64'd0);

    // Reset at line 7, x=10
    chk_pix = 1'b0;
    e0 = err_cnt;
    drive_lines(0, 7, -1, M_NONE);
    drive_line(7, 0, 10, H_ACT, 1'b0);
    rst = 1'b0;
    drive_line(7, 10, 13, H_ACT, 1'b0);
    check("mid_rst_pix", 64'({pix_valid, pix_data, pix_x,
          pix_y, line_start, frame_start}), 64'd0);
    check("mid_rst_stat", 64'({h_period, v_period,
          locked, fmt_err}), 64'd0);
    rst = 1'b1;
    drive_line(7, 13, H_TOT, H_ACT, 1'b0);
    drive_lines(8, V_TOT, -1, M_NONE);
    check("post_rst_lock0", 64'(locked), 64'd0);
    frame();
    check("post_rst_lock1", 64'(locked), 64'd0);
    frame();
    check("post_rst_lock2", 64'(locked), 64'd1);
    check("post_rst_err", 64'(err_cnt - e0), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
